// File: rtl/entry_conditioner.sv
// Button/digit input conditioner ahead of the combination-lock FSM: synchronizes, debounces,
// emits one strobe per clean press and counts entries. Optional macro: INVALID_DIGIT_BLOCK_EN.
module entry_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2,
  parameter int MAX_DIGIT       = 9,
  parameter int SEQ_LEN         = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       insere_raw_n,
  input  logic [3:0] number_raw,
  output logic       insere_strobe_n,
  output logic [3:0] number_out,
  output logic       digit_valid,
  output logic       digit_invalid,
  output logic [2:0] entry_count,
  output logic       seq_full
);

  localparam int          CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]  MAX_D    = 4'(MAX_DIGIT);
  localparam logic [2:0]  SEQ_MAX  = 3'(SEQ_LEN);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    FIRE         = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0]      btn_sync;
  logic [SYNC_STAGES-1:0][3:0] num_sync;
  logic                        btn_s;
  logic [3:0]                  num_s;
  logic                        num_ok;
  state_t                      state;
  logic [CW-1:0]               count;

  assign btn_s    = btn_sync[SYNC_STAGES-1];
  assign num_s    = num_sync[SYNC_STAGES-1];
  assign num_ok   = (num_s <= MAX_D);
  assign seq_full = (entry_count == SEQ_MAX);

  // Metastability chains; the button idles released so no press is seen out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_sync <= '1;
      num_sync <= '0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], insere_raw_n};
      num_sync <= {num_sync[SYNC_STAGES-2:0], number_raw};
    end
  end

  // Debounce FSM; the fire outputs are registered on the edge that enters FIRE,
  // so they are visible exactly while the FSM sits in FIRE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      insere_strobe_n <= 1'b1;
      number_out      <= 4'd0;
      digit_valid     <= 1'b0;
      digit_invalid   <= 1'b0;
      entry_count     <= 3'd0;
    end else begin
      insere_strobe_n <= 1'b1;
      digit_valid     <= 1'b0;
      digit_invalid   <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (!btn_s) begin
            state <= PRESS_WAIT;
          end else begin
            state <= IDLE;
          end
        end
        PRESS_WAIT: begin
          if (btn_s) begin
            state <= IDLE;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state         <= FIRE;
            count         <= '0;
            digit_valid   <= num_ok;
            digit_invalid <= !num_ok;
`ifdef INVALID_DIGIT_BLOCK_EN
            if (num_ok) begin
              insere_strobe_n <= 1'b0;
              number_out      <= num_s;
              if (entry_count < SEQ_MAX) begin
                entry_count <= entry_count + 3'd1;
              end else begin
                entry_count <= entry_count;
              end
            end else begin
              number_out <= number_out;
            end
`else
            insere_strobe_n <= 1'b0;
            number_out      <= num_s;
            if (entry_count < SEQ_MAX) begin
              entry_count <= entry_count + 3'd1;
            end else begin
              entry_count <= entry_count;
            end
`endif
          end else begin
            count <= count + CW'(1);
          end
        end
        FIRE: begin
          state <= HELD;
          count <= '0;
        end
        HELD: begin
          count <= '0;
          if (btn_s) begin
            state <= RELEASE_WAIT;
          end else begin
            state <= HELD;
          end
        end
        RELEASE_WAIT: begin
          if (!btn_s) begin
            state <= HELD;
            count <= '0;
          end else if (count == CNT_LAST) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule
